// File: rtl/dp_acc_pkg.sv
// dp_acc_pkg: shared types, widths and helpers for the dot-product accumulator
package dp_acc_pkg;
  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
  localparam int OPW = 4;
  localparam int PRODW = 8;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dp_acc_if.sv
// dp_acc_if: operand-in and result-out valid/ready ports of the accumulator
interface dp_acc_if import dp_acc_pkg::*; #(parameter int ACC_W = 11);
  logic in_valid;
  logic in_ready;
  logic [OPW-1:0] in_x;
  logic [OPW-1:0] in_y;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_sum;
  logic out_ovf;
  modport master(output in_valid, in_x, in_y, out_ready, input in_ready, out_valid, out_sum, out_ovf);
  modport slave(input in_valid, in_x, in_y, out_ready, output in_ready, out_valid, out_sum, out_ovf);
endinterface

// File: rtl/parallel_multiplier.sv
// parallel_multiplier: 4x4 unsigned combinational array multiplier
module parallel_multiplier import dp_acc_pkg::*; (
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] p
);
  // sum of AND-gated partial-product rows, each shifted by its multiplier bit
  always_comb begin
    p = '0;
    for (int i = 0; i < OPW; i++) p = p + (PRODW'({OPW{b[i]}} & a) << i);
  end
endmodule

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: accumulates N_TERMS operand products into one handshaked result
module dot_product_accumulator import dp_acc_pkg::*; #(
  parameter int N_TERMS = 8,
  parameter int ACC_W = 11
) (
  input logic clk,
  input logic rst_n,
  dp_acc_if.slave bus
);
  localparam int CW = cnt_w(N_TERMS);
  state_t state;
  logic [CW-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic ovf;
  logic [PRODW-1:0] prod;
  logic [PRODW-1:0] prod_q;
  logic prod_v;
  logic accept;
  logic [ACC_W:0] sum;
  logic out_valid;
  logic [ACC_W-1:0] out_sum;
  logic out_ovf;
  parallel_multiplier u_mul (.a(bus.in_x), .b(bus.in_y), .p(prod));
  assign bus.in_ready = (state == ACCUM) && (cnt < CW'(N_TERMS));
  assign accept = bus.in_valid && bus.in_ready;
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod_q);
  assign bus.out_valid = out_valid;
  assign bus.out_sum = out_sum;
  assign bus.out_ovf = out_ovf;
  // product register, running accumulator and frame FSM; DRAIN folds in the last product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
      prod_q <= '0;
      prod_v <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        prod_q <= prod;
        cnt <= cnt + CW'(1);
      end
      if (prod_v) begin
        acc <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
      end
      case (state)
        ACCUM: if (accept && cnt == CW'(N_TERMS - 1)) state <= DRAIN;
        DRAIN: begin
          out_sum <= sum[ACC_W-1:0];
          out_ovf <= ovf | sum[ACC_W];
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid <= 1'b0;
          acc <= '0;
          ovf <= 1'b0;
          cnt <= '0;
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb_dot_product_accumulator: vector table, corner sequences and random frames vs a sum-of-products model
module tb_dot_product_accumulator;
  import dp_acc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  localparam int NT [3] = '{4, 8, 2};
  localparam int AW [3] = '{11, 11, 8};
  logic iv [3];
  logic orr [3];
  logic [3:0] ix [3];
  logic [3:0] iy [3];
  logic ir [3];
  logic ov [3];
  logic oo [3];
  logic [10:0] os [3];
  dp_acc_if #(.ACC_W(11)) b0 ();
  dp_acc_if #(.ACC_W(11)) b1 ();
  dp_acc_if #(.ACC_W(8)) b2 ();
  assign b0.in_valid = iv[0];
  assign b0.in_x = ix[0];
  assign b0.in_y = iy[0];
  assign b0.out_ready = orr[0];
  assign ir[0] = b0.in_ready;
  assign ov[0] = b0.out_valid;
  assign oo[0] = b0.out_ovf;
  assign os[0] = b0.out_sum;
  assign b1.in_valid = iv[1];
  assign b1.in_x = ix[1];
  assign b1.in_y = iy[1];
  assign b1.out_ready = orr[1];
  assign ir[1] = b1.in_ready;
  assign ov[1] = b1.out_valid;
  assign oo[1] = b1.out_ovf;
  assign os[1] = b1.out_sum;
  assign b2.in_valid = iv[2];
  assign b2.in_x = ix[2];
  assign b2.in_y = iy[2];
  assign b2.out_ready = orr[2];
  assign ir[2] = b2.in_ready;
  assign ov[2] = b2.out_valid;
  assign oo[2] = b2.out_ovf;
  assign os[2] = {3'b000, b2.out_sum};
  dot_product_accumulator #(.N_TERMS(4), .ACC_W(11)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  dot_product_accumulator #(.N_TERMS(8), .ACC_W(11)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  dot_product_accumulator #(.N_TERMS(2), .ACC_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  typedef struct {
    int d;
    int n;
    logic [7:0][3:0] x;
    logic [7:0][3:0] y;
    int es;
    bit eo;
    int hold;
    bit gaps;
  } vec_t;
  vec_t vecs [5];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int d, input logic [3:0] x, input logic [3:0] y, input bit gaps);
    if (gaps) while ($urandom_range(0, 2) == 0) begin
      iv[d] = 1'b0;
      ix[d] = 4'($urandom);
      iy[d] = 4'($urandom);
      step();
    end
    iv[d] = 1'b1;
    ix[d] = x;
    iy[d] = y;
    for (int g = 0; g < 50 && !ir[d]; g++) step();
    chk("in_ready_wait", int'(ir[d]), 1);
    step();
    iv[d] = 1'b0;
    ix[d] = 4'($urandom);
    iy[d] = 4'($urandom);
  endtask
  task automatic collect(input int d, input int es, input bit eo, input int hold);
    for (int g = 0; g < 20 && !ov[d]; g++) step();
    chk("out_valid_wait", int'(ov[d]), 1);
    chk("out_sum", int'(os[d]), es);
    chk("out_ovf", int'(oo[d]), int'(eo));
    for (int h = 0; h < hold; h++) begin
      iv[d] = 1'b1;
      ix[d] = 4'd15;
      iy[d] = 4'd15;
      step();
      chk("hold_valid", int'(ov[d]), 1);
      chk("hold_sum", int'(os[d]), es);
      chk("hold_ovf", int'(oo[d]), int'(eo));
      chk("hold_in_ready", int'(ir[d]), 0);
    end
    iv[d] = 1'b0;
    orr[d] = 1'b1;
    step();
    orr[d] = 1'b0;
    chk("handoff_valid", int'(ov[d]), 0);
    chk("handoff_in_ready", int'(ir[d]), 1);
  endtask
  initial begin
    vecs[0] = '{d: 1, n: 8, x: 32'hFFFF_FFFF, y: 32'hFFFF_FFFF, es: 1800, eo: 1'b0, hold: 0, gaps: 1'b1};
    vecs[1] = '{d: 2, n: 2, x: 32'h0000_00FF, y: 32'h0000_00FF, es: 194, eo: 1'b1, hold: 0, gaps: 1'b0};
    vecs[2] = '{d: 2, n: 2, x: 32'h0000_0011, y: 32'h0000_0011, es: 2, eo: 1'b0, hold: 0, gaps: 1'b0};
    vecs[3] = '{d: 0, n: 4, x: 32'h0000_7531, y: 32'h0000_8642, es: 100, eo: 1'b0, hold: 5, gaps: 1'b0};
    vecs[4] = '{d: 0, n: 4, x: 32'h0000_1111, y: 32'h0000_1111, es: 4, eo: 1'b0, hold: 0, gaps: 1'b1};
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      orr[d] = 1'b0;
      ix[d] = '0;
      iy[d] = '0;
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", int'(ir[d]), 1);
      chk("rst_out_valid", int'(ov[d]), 0);
      chk("rst_out_sum", int'(os[d]), 0);
      chk("rst_out_ovf", int'(oo[d]), 0);
    end
    orr[0] = 1'b1;
    send(0, 4'd3, 4'd5, 1'b0);
    send(0, 4'd15, 4'd15, 1'b0);
    send(0, 4'd0, 4'd9, 1'b0);
    send(0, 4'd7, 4'd2, 1'b0);
    chk("t1_not_yet_valid", int'(ov[0]), 0);
    step();
    chk("t1_valid", int'(ov[0]), 1);
    chk("t1_sum", int'(os[0]), 254);
    chk("t1_ovf", int'(oo[0]), 0);
    step();
    orr[0] = 1'b0;
    chk("t1_one_cycle", int'(ov[0]), 0);
    chk("t1_in_ready", int'(ir[0]), 1);
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++) send(vecs[v].d, vecs[v].x[i], vecs[v].y[i], vecs[v].gaps);
      collect(vecs[v].d, vecs[v].es, vecs[v].eo, vecs[v].hold);
    end
    send(0, 4'd9, 4'd9, 1'b0);
    send(0, 4'd9, 4'd9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sum0", int'(os[0]), 0);
    chk("rst_mid_valid0", int'(ov[0]), 0);
    chk("rst_mid_ovf0", int'(oo[0]), 0);
    chk("rst_mid_ready0", int'(ir[0]), 1);
    chk("rst_mid_sum2", int'(os[2]), 0);
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(0, 4'd2, 4'd3, 1'b0);
    collect(0, 24, 1'b0, 0);
    for (int r = 0; r < 12; r++) begin
      int d;
      int total;
      logic [3:0] x;
      logic [3:0] y;
      d = $urandom_range(0, 2);
      total = 0;
      for (int i = 0; i < NT[d]; i++) begin
        x = 4'($urandom);
        y = 4'($urandom);
        total += int'(x) * int'(y);
        send(d, x, y, 1'b1);
      end
      collect(d, total % (1 << AW[d]), total >= (1 << AW[d]), $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
